// File: rtl/falu_seq_if.sv
//------------------------------------------------------------------------------
// Module  : falu_seq_if
// Brief   : Command/response handshake bundle for the FP ALU sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface falu_seq_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_a;
  logic [63:0]      cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_y;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_div0;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_tag, rsp_div0
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_tag, rsp_div0
  );
endinterface

`default_nettype wire

// File: rtl/falu_seq.sv
//------------------------------------------------------------------------------
// Module  : falu_seq
// Brief   : Buffers tagged FP ALU commands, issues one at a time, returns
//           tagged results. Optional divide-by-zero flag: FALU_SEQ_DIV0_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module falu_seq #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  falu_seq_if.slave        bus,
  output logic [63:0]      ia,
  output logic [63:0]      ib,
  output logic [1:0]       op,
  input  wire logic [63:0] oy,
  output logic             busy
);

  localparam int c_PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  cmd_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  state_t             r_state;
  logic [c_LAT_W-1:0] r_cnt;
  logic [TAG_W-1:0]   r_tag;
  logic               r_rsp_valid;
  logic [63:0]        r_rsp_y;
  logic [TAG_W-1:0]   r_rsp_tag;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  cmd_t               w_head;

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  assign bus.cmd_ready = !w_full;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_tag   = r_rsp_tag;
  assign busy          = !w_empty || (r_state != S_IDLE);

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: bus.cmd_tag};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FALU_SEQ_DIV0_EN
  logic r_div0_pend;
  logic r_rsp_div0;

  assign bus.rsp_div0 = r_rsp_div0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div0_pend <= 1'b0;
      r_rsp_div0  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_div0_pend <= (w_head.op == 2'b11) && (w_head.b[62:0] == 63'd0);
      end
      if ((r_state == S_WAIT) && (r_cnt == c_LAT_W'(1))) begin
        r_rsp_div0 <= r_div0_pend;
      end
    end
  end
`else
  assign bus.rsp_div0 = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tag       <= '0;
      ia          <= '0;
      ib          <= '0;
      op          <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            ia      <= w_head.a;
            ib      <= w_head.b;
            op      <= w_head.op;
            r_tag   <= w_head.tag;
            r_cnt   <= c_LAT_W'(ALU_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == c_LAT_W'(1)) begin
            r_rsp_y     <= oy;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_falu_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_falu_seq
// Brief   : Table and scoreboard bench for falu_seq with a behavioural FP ALU.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_falu_seq;
  localparam int TAG_W = 4;
`ifdef FALU_SEQ_DIV0_EN
  localparam bit DIV0_ON = 1'b1;
`else
  localparam bit DIV0_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] ia, ib, oy;
  logic [1:0]  op;
  logic        busy;

  always #5 clock = ~clock;

  falu_seq_if #(.TAG_W(TAG_W)) bus ();

  falu_seq #(.DEPTH(4), .ALU_LAT(1), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .ia    (ia),
    .ib    (ib),
    .op    (op),
    .oy    (oy),
    .busy  (busy)
  );

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] o);
    real ra, rb, r;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    r  = 0.0;
    case (o)
      2'b00: r = ra + rb;
      2'b01: r = ra - rb;
      2'b10: r = ra * rb;
      default: begin
        if (b[62:0] == 63'd0) return {a[63] ^ b[63], 11'h7FF, 52'd0};
        r = ra / rb;
      end
    endcase
    return $realtobits(r);
  endfunction

  always_comb oy = alu_model(ia, ib, op);

  typedef struct {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [63:0]      y;
  } vec_t;

  typedef struct {
    logic [63:0]      y;
    logic [TAG_W-1:0] tag;
    logic             div0;
  } exp_t;

  exp_t exp_q[$];
  int   resp_cyc[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   accepted = 0;
  vec_t tv[6];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check64(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic vec_t mk(input int k, input logic [1:0] o);
    vec_t v;
    v.a   = $realtobits(real'(k + 1));
    v.b   = $realtobits(2.0);
    v.op  = o;
    v.tag = TAG_W'(k);
    v.y   = alu_model(v.a, v.b, o);
    return v;
  endfunction

  // Scoreboard: compare each response on the cycle it is handshaked.
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %0d want no response", bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check64("rsp_y", bus.rsp_y, e.y);
        check64("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
        check64("rsp_div0", 64'(bus.rsp_div0), 64'(e.div0));
        resp_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input vec_t v);
    int t = 0;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_op    = v.op;
    bus.cmd_tag   = v.tag;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    while (!bus.cmd_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd_ready got 0 want 1");
    end else begin
      exp_q.push_back('{y: v.y, tag: v.tag,
                        div0: DIV0_ON && (v.op == 2'b11) && (v.b[62:0] == 63'd0)});
      accepted++;
    end
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(posedge clock);
      #1;
      t++;
    end
    check64("drain_timeout", 64'(t >= 500), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_ia"}, ia, 64'd0);
    check64({tag, "_ib"}, ib, 64'd0);
    check64({tag, "_op"}, 64'(op), 64'd0);
    check64({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check64({tag, "_rsp_y"}, bus.rsp_y, 64'd0);
    check64({tag, "_rsp_tag"}, 64'(bus.rsp_tag), 64'd0);
    check64({tag, "_rsp_div0"}, 64'(bus.rsp_div0), 64'd0);
    check64({tag, "_busy"}, 64'(busy), 64'd0);
    check64({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tv[0] = '{64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 4'd5, 64'h400C000000000000};
    tv[1] = '{64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 4'd0, 64'h400C000000000000};
    tv[2] = '{64'h3FF8000000000000, 64'h4000000000000000, 2'b01, 4'd1, 64'hBFE0000000000000};
    tv[3] = '{64'h3FF8000000000000, 64'h4000000000000000, 2'b10, 4'd2, 64'h4008000000000000};
    tv[4] = '{64'h3FF8000000000000, 64'h4000000000000000, 2'b11, 4'd3, 64'h3FE8000000000000};
    tv[5] = '{64'h3FF0000000000000, 64'h8000000000000000, 2'b11, 4'd9, 64'hFFF0000000000000};

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("reset");

    // Single add: latency and busy release.
    send(tv[0]);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check64("latency_edges", 64'(n), 64'd2);
    check64("busy_in_resp", 64'(busy), 64'd1);
    @(posedge clock);
    #1;
    check64("busy_after_rsp", 64'(busy), 64'd0);

    // Back-to-back ops with full-rate response acceptance.
    resp_cyc.delete();
    for (int i = 1; i <= 4; i++) send(tv[i]);
    wait_drain();
    check64("b2b_count", 64'(resp_cyc.size()), 64'd4);
    if (resp_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check64("b2b_spacing", 64'(resp_cyc[i] - resp_cyc[i-1]), 64'd3);
      end
    end

    // Divide by signed zero.
    send(tv[5]);
    wait_drain();

    // Backpressure: 4 in FIFO plus 1 held in RESP, 6th must wait.
    bus.rsp_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(mk(k, 2'(k % 4)));
      end
    join_none
    repeat (15) @(posedge clock);
    #1;
    check64("bp_accepted", 64'(accepted), 64'd5);
    check64("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check64("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    wait_drain();
    check64("bp_accepted_all", 64'(accepted), 64'd6);

    // Push and pop on the same edge at count 2, then wrap pointers.
    bus.rsp_ready = 1'b0;
    send(mk(0, 2'b00));
    send(mk(1, 2'b01));
    send(mk(2, 2'b10));
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    send(mk(3, 2'b11));
    send(mk(4, 2'b00));
    check64("pp_count3_ready", 64'(bus.cmd_ready), 64'd1);
    send(mk(5, 2'b01));
    check64("pp_count4_ready", 64'(bus.cmd_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    for (int k = 6; k < 10; k++) send(mk(k, 2'(k % 4)));
    wait_drain();

    // Asynchronous reset while a command is in WAIT with 2 queued.
    bus.rsp_ready = 1'b0;
    send(mk(10, 2'b00));
    send(mk(11, 2'b01));
    send(mk(12, 2'b10));
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    send(mk(13, 2'b11));
    check64("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("async_reset");
    @(negedge clock);
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check64("post_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check64("post_reset_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
